// File: rtl/seven_seg_mux_scanner.sv
// Time-multiplexed seven-segment scanner with per-digit skip, programmable
// dwell and blanking, on-chip hex decode, decimal points and frame strobe.
module seven_seg_mux_scanner #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int DWELL_CYCLES = 4,
  parameter  int BLANK_CYCLES = 1,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    div_clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_RST    = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    nxt_found;
  logic [IDX_W-1:0]        nxt_idx;
  logic [3:0]              nxt_nib;
  logic                    blank_done;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_DIGITS) s = s - NUM_DIGITS;
    return IDX_W'(s);
  endfunction

  // Upward search with wrap; descending loop so the nearest enabled digit wins
  // and the current digit (k == NUM_DIGITS) is considered last.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = idx_q;
    for (int k = NUM_DIGITS; k >= 1; k--) begin
      if (digit_en[wrap_add(idx_q, k)]) begin
        nxt_found = 1'b1;
        nxt_idx   = wrap_add(idx_q, k);
      end
    end
  end

  assign nxt_nib    = digits[{nxt_idx, 2'b00} +: 4];
  assign blank_done = (BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    anode_d = anode_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    frame_d = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (blank_done) begin
          cnt_d = '0;
          if (nxt_found) begin
            state_d = ST_ON;
            idx_d   = nxt_idx;
            anode_d = ~(NUM_DIGITS'(1) << nxt_idx);
            seg_d   = hex_to_seg(nxt_nib);
            dp_d    = ~dp_in[nxt_idx];
            frame_d = (nxt_idx <= idx_q);
          end
        end
      end
      default: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if ((BLANK_CYCLES == 0) && nxt_found) begin
            idx_d   = nxt_idx;
            anode_d = ~(NUM_DIGITS'(1) << nxt_idx);
            seg_d   = hex_to_seg(nxt_nib);
            dp_d    = ~dp_in[nxt_idx];
            frame_d = (nxt_idx <= idx_q);
          end else begin
            state_d = ST_BLANK;
            anode_d = '1;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge div_clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= IDX_RST;
      anode_q <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_q;

endmodule

// File: doc/seven_seg_mux_scanner.md
Name: seven_seg_mux_scanner

Overview:
Parametrised successor to the 4-anode seven-segment scanner. Time-multiplexes NUM_DIGITS hex digits onto one shared active-low segment bus. Adds per-digit enable/skip, a programmable dwell time, and anti-ghosting blanking between digits. Also provides an on-chip hex decoder, decimal points and a frame-complete strobe. Sits between display-data registers and the board's anode, segment and dp pins, clocked by the divided scan clock.

Parameters:
NUM_DIGITS, 4, number of digits/anodes; legal 1..16; anode bit 0 = rightmost digit.
DWELL_CYCLES, 4, div_clock cycles each digit is lit; legal >= 1.
BLANK_CYCLES, 1, div_clock cycles with all anodes off between digits; legal >= 0 (0 = no blank phase).
(localparam IDX_W = max(1, clog2(NUM_DIGITS)))

Ports:
div_clock  in  1  scan clock; all state on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
digit_en  in  NUM_DIGITS  1 = digit participates in the scan; 0 = skipped entirely
digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i]
dp_in  in  NUM_DIGITS  active-high decimal point per digit
anode  out  NUM_DIGITS  active-low anode drive; at most one bit 0
seg  out  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a
dp  out  1  active-low decimal point
digit_idx  out  IDX_W  index of the digit currently or last lit
frame_done  out  1  one-cycle pulse at the start of each new scan frame

Behaviour:
- All outputs are registered; none depend combinationally on inputs.
- Reset (async, reset==0): state=BLANK, phase counter=0, digit_idx=NUM_DIGITS-1, anode=all 1s, seg=7'h7F, dp=1, frame_done=0.
- States: BLANK and ON.
- BLANK:
  - anode all 1s, seg=7'h7F, dp=1.
  - Counter runs 0..BLANK_CYCLES-1.
  - On the edge where count==BLANK_CYCLES-1, look for the next enabled index after digit_idx, searching upward with wrap and including digit_idx itself last.
  - If one exists: digit_idx <= that index, state <= ON, counter <= 0.
  - If none exists (digit_en all 0): remain in BLANK and restart the count.
- BLANK_CYCLES==0: the BLANK state is never occupied. Transitions out of ON go directly to the next enabled digit's ON. Reset exits via the same next-digit search on the first edge.
  - If digit_en is all 0 in this mode: anode all 1s, seg=7'h7F, dp=1, idx held.
- Entry into ON:
  - On the same edge: anode <= one-cold at the new idx, seg <= decode(digits nibble), dp <= ~dp_in[idx].
  - Nibble and dp are latched here and held for the whole dwell. Mid-dwell changes to digits or dp_in do not affect the outputs.
- ON:
  - Counter runs 0..DWELL_CYCLES-1.
  - On the edge where count==DWELL_CYCLES-1: go to BLANK, or straight to the next ON when BLANK_CYCLES==0.
- digit_en mid-operation:
  - Sampled only at the next-digit search.
  - Clearing the bit of the currently lit digit does not cut its dwell short.
  - A newly enabled digit is picked up at the next search.
- Lit duration per visit = DWELL_CYCLES cycles. Frame period = (DWELL_CYCLES+BLANK_CYCLES) × popcount(digit_en).
- frame_done:
  - Pulses 1 for exactly one cycle, coincident with the first cycle of ON, when the new idx <= the previous idx (wrap).
  - With a single enabled digit, it pulses on every visit.
  - No pulse while no digit is enabled.
- Decode (active-low, hex g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariant: anode never has more than one 0 bit. At most one bit changes 1->0 per edge.
- Reset assertion mid-dwell immediately (asynchronously) forces all-off outputs. Release restarts from the reset state.

Test Plan:
1. Reset and scan order: defaults, digits=16'h3210, dp_in=0, digit_en=4'hF. Release reset → anode=1111 for 1 cycle, then 1110 ×4, 1111 ×1, 1101 ×4, … 0111. seg=40,79,24,30 in turn; frame_done high on the first 1110 cycle only.
2. Skip and all-disabled: digit_en=4'b0101 → anode alternates 1110/1011 only, digit_idx alternates 0/2. Set digit_en=0 → anode and seg stay 1111/7F indefinitely, frame_done stays 0. Re-enable bit 3 → 0111 follows after one blank.
3. Data stability and dp: change digits[3:0] from 8 to F in the middle of digit 0's dwell → seg stays 00 until the next visit, then 0E. dp_in[1]=1 → dp=0 only while anode=1101.
4. BLANK_CYCLES=0, DWELL_CYCLES=1, NUM_DIGITS=8, all enabled → anode walks one-cold 11111110..01111111 on consecutive cycles with no all-off gap; frame_done every 8 cycles.
5. Async reset mid-dwell: assert reset between clock edges while anode=1011 → anode=1111, seg=7F, dp=1 before the next edge. After release, the first lit digit is 0.
6. Single digit, NUM_DIGITS=1: digit_en=1, digits=4'hA → anode 0 for 4 cycles, 1 for 1 cycle, repeating; seg=08; frame_done every 5 cycles; the one-cold invariant is checked by assertion throughout.
